sha_msg_padder: RTL and testbench

- Front-end initiator for the SHA-256 core.
- Accepts a byte stream with a valid/ready handshake and applies FIPS 180-4 padding: 0x80, then zeros, then the 64-bit big-endian bit length.
- Emits 512-bit blocks with a one-cycle start pulse and waits for the core's valid before issuing the next block.
- Flags the final block so that its digest can be captured and reported as the message hash.

---
 rtl/sha_msg_padder.sv | 123 ++++++++++++
 tb/tb_sha_msg_padder.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/sha_msg_padder.sv
// sha_msg_padder: FIPS 180-4 padder turning a byte stream into 512-bit SHA-256 blocks.
// Define SHA_PAD_MAXLEN_EN to enforce MAX_BYTES with a sticky err flag.
module sha_msg_padder #(
    parameter int LEN_W     = 64,
    parameter int MAX_BYTES = 65535
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [7:0]   in_data,
    input  logic         in_last,
    input  logic         in_empty,
    output logic         start,
    output logic         first,
    output logic [511:0] message,
    input  logic         core_valid,
    input  logic [255:0] hashvalue_in,
    output logic [255:0] hash_out,
    output logic         done,
    output logic         err
);
    typedef enum logic [2:0] {IDLE, FILL, PAD, PAD2, ISSUE, WAIT, DROP} state_t;
    state_t state_q, ret_q;
    logic [6:0] idx_q, ix, nx;
    logic [LEN_W-1:0] bitlen_q, len, nlen;
    logic [511:0] buf_q, pad_blk;
    logic [255:0] hash_q;
    logic last_q, first_q, done_q, acc, byte_ok, over;

    assign in_ready = !clr && (state_q inside {IDLE, FILL, DROP});
    assign acc      = in_valid && in_ready;
    assign byte_ok  = !(in_last && in_empty);
    // A new message restarts index and length from zero on its first beat
    assign ix       = state_q == IDLE ? 7'd0 : idx_q;
    assign len      = state_q == IDLE ? '0 : bitlen_q;
    assign nx       = ix + {6'd0, byte_ok};
    assign nlen     = len + (byte_ok ? LEN_W'(8) : '0);
    assign start    = state_q == ISSUE;
    assign first    = start && first_q;
    assign message  = buf_q;
    assign hash_out = hash_q;
    assign done     = done_q;

    always_comb begin
        pad_blk = '0;
        for (int i = 0; i < 64; i++)
            pad_blk[511-8*i -: 8] = i < int'(idx_q) ? buf_q[511-8*i -: 8] :
                                    (i == int'(idx_q) ? 8'h80 : 8'h00);
        if (idx_q <= 7'd55) pad_blk[LEN_W-1:0] = bitlen_q;
    end

`ifdef SHA_PAD_MAXLEN_EN
    logic err_q;
    assign over = byte_ok && len == LEN_W'(MAX_BYTES) * LEN_W'(8);
    assign err  = err_q;
    always_ff @(posedge clk or posedge clr)
        if (clr) err_q <= 1'b0;
        else if (acc && over && state_q != DROP) err_q <= 1'b1;
`else
    assign over = 1'b0;
    assign err  = 1'b0;
`endif

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q  <= IDLE;
            ret_q    <= FILL;
            idx_q    <= '0;
            bitlen_q <= '0;
            buf_q    <= '0;
            hash_q   <= '0;
            last_q   <= 1'b0;
            first_q  <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE, FILL: if (acc) begin
                    if (state_q == IDLE) first_q <= 1'b1;
                    if (over) state_q <= in_last ? IDLE : DROP;
                    else begin
                        if (byte_ok) buf_q[{6'd63 - ix[5:0], 3'b000} +: 8] <= in_data;
                        idx_q    <= nx;
                        bitlen_q <= nlen;
                        if (nx[6]) begin
                            state_q <= ISSUE;
                            last_q  <= 1'b0;
                            ret_q   <= in_last ? PAD : FILL;
                        end else state_q <= in_last ? PAD : FILL;
                    end
                end
                DROP: if (acc && in_last) state_q <= IDLE;
                PAD: begin
                    buf_q   <= pad_blk;
                    last_q  <= (idx_q <= 7'd55);
                    ret_q   <= PAD2;
                    state_q <= ISSUE;
                end
                PAD2: begin
                    buf_q   <= {{(512-LEN_W){1'b0}}, bitlen_q};
                    last_q  <= 1'b1;
                    state_q <= ISSUE;
                end
                ISSUE: begin
                    first_q <= 1'b0;
                    state_q <= WAIT;
                end
                WAIT: if (core_valid) begin
                    if (last_q) begin
                        hash_q  <= hashvalue_in;
                        done_q  <= 1'b1;
                        state_q <= IDLE;
                    end else begin
                        idx_q   <= '0;
                        state_q <= ret_q;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sha_msg_padder.sv
// tb_sha_msg_padder: directed vectors for the SHA-256 message padder.
module tb_sha_msg_padder;
`ifdef SHA_PAD_MAXLEN_EN
    localparam int MAXB = 4;
`else
    localparam int MAXB = 65535;
`endif
    localparam logic [255:0] H_ABC   = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [255:0] H_EMPTY = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
    localparam logic [255:0] H_56    = 256'h0123456789abcdef0011223344556677_8899aabbccddeeff_fedcba9876543210;
    localparam logic [255:0] H_64    = 256'hdeadbeefcafef00d5a5aa5a50f0ff0f01234432156788765_9abccba9def00fed;

    logic clk = 1'b0, clr, in_valid, in_last, in_empty, core_valid;
    logic [7:0] in_data;
    logic [255:0] hashvalue_in, hash_out;
    logic in_ready, start, first, done, err;
    logic [511:0] message;
    int checks = 0, errors = 0, nstart = 0;

    sha_msg_padder #(.LEN_W(64), .MAX_BYTES(MAXB)) dut (
        .clk(clk), .clr(clr), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_last(in_last), .in_empty(in_empty),
        .start(start), .first(first), .message(message),
        .core_valid(core_valid), .hashvalue_in(hashvalue_in),
        .hash_out(hash_out), .done(done), .err(err)
    );

    always #5 clk = ~clk;
    always @(negedge clk) if (start) nstart++;

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [7:0] d, input logic l, input logic e);
        int n;
        @(negedge clk);
        in_valid = 1'b1; in_data = d; in_last = l; in_empty = e;
        n = 0;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) chk("send_timeout", 0, 1);
        @(posedge clk);
        #1 in_valid = 1'b0; in_last = 1'b0; in_empty = 1'b0;
    endtask

    // Waits for start, checks the block, then checks start drops after one cycle.
    task automatic blk(input string tag, input logic [511:0] exp, input logic f, input int lat);
        int n;
        @(negedge clk);
        n = 1;
        while (!start && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_start_seen"}, start, 1);
        if (lat > 0) chk({tag, "_latency"}, n, lat);
        chk({tag, "_msg"}, message, exp);
        chk({tag, "_first"}, first, f);
        @(negedge clk);
        chk({tag, "_start_pulse"}, start, 0);
    endtask

    task automatic core_resp(input logic [255:0] h);
        @(negedge clk);
        hashvalue_in = h; core_valid = 1'b1;
        @(negedge clk);
        core_valid = 1'b0;
    endtask

    task automatic fin(input string tag, input logic [255:0] h);
        core_resp(h);
        chk({tag, "_done"}, done, 1);
        chk({tag, "_hash"}, hash_out, h);
        @(negedge clk);
        chk({tag, "_done_pulse"}, done, 0);
    endtask

    task automatic mid(input string tag, input logic [255:0] hold);
        core_resp(~hold);
        chk({tag, "_mid"}, {done, hash_out}, {1'b0, hold});
    endtask

    initial begin
        logic [511:0] exp;
        logic ok;
        int n;
        clr = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; in_empty = 1'b0;
        core_valid = 1'b0; hashvalue_in = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_outs", {in_ready, start, first, done, err, hash_out}, 0);
        chk("rst_msg", message, 0);
        @(negedge clk) clr = 1'b0;
        @(negedge clk) chk("idle_ready", in_ready, 1);
        core_valid = 1'b1; hashvalue_in = '1;
        @(negedge clk) core_valid = 1'b0;
        @(negedge clk) chk("stray_core_valid", {start, done, hash_out}, 0);

        send(8'h61, 0, 0); send(8'h62, 0, 0); send(8'h63, 1, 0);
        exp = '0; exp[511:480] = 32'h61626380; exp[63:0] = 64'h18;
        blk("abc", exp, 1, 2);
        fin("abc", H_ABC);
        chk("abc_nstart", nstart, 1);

        send(8'h00, 1, 1);
        exp = '0; exp[511:504] = 8'h80;
        blk("empty", exp, 1, 2);
        fin("empty", H_EMPTY);

`ifdef SHA_PAD_MAXLEN_EN
        n = nstart;
        for (int i = 0; i < 4; i++) send(8'(i + 1), 0, 0);
        chk("err_lo", err, 0);
        send(8'h05, 0, 0);
        chk("err_hi", err, 1);
        send(8'h06, 1, 0);
        @(negedge clk) chk("err_idle", in_ready, 1);
        repeat (4) @(negedge clk);
        chk("err_nostart", nstart, n);
        chk("err_sticky", err, 1);
`else
        for (int i = 0; i < 56; i++) send(8'(i + 1), i == 55, 0);
        exp = '0;
        for (int i = 0; i < 56; i++) exp[511-8*i -: 8] = 8'(i + 1);
        exp[511-8*56 -: 8] = 8'h80;
        blk("b56a", exp, 1, 2);
        mid("b56", H_EMPTY);
        exp = '0; exp[63:0] = 64'h1C0;
        blk("b56b", exp, 0, 0);
        fin("b56", H_56);

        for (int i = 0; i < 64; i++) send(8'(i) ^ 8'hA5, i == 63, 0);
        exp = '0;
        for (int i = 0; i < 64; i++) exp[511-8*i -: 8] = 8'(i) ^ 8'hA5;
        blk("b64a", exp, 1, 1);
        ok = 1'b1;
        in_valid = 1'b1; in_data = 8'hFF;
        repeat (20) @(negedge clk) if (in_ready || start || message !== exp) ok = 1'b0;
        in_valid = 1'b0;
        chk("b64_stall", ok, 1);
        mid("b64", H_56);
        exp = '0; exp[511:504] = 8'h80; exp[63:0] = 64'h200;
        blk("b64b", exp, 0, 0);
        fin("b64", H_64);

        for (int i = 0; i < 64; i++) send(8'(i), 0, 0);
        exp = '0;
        for (int i = 0; i < 64; i++) exp[511-8*i -: 8] = 8'(i);
        blk("abort", exp, 1, 1);
        @(negedge clk) clr = 1'b1;
        #1;
        chk("clr_outs", {in_ready, start, first, done, err, hash_out}, 0);
        chk("clr_msg", message, 0);
        @(negedge clk) clr = 1'b0;
        n = nstart;
        repeat (5) @(negedge clk);
        chk("clr_nostart", {nstart, done}, {n, 1'b0});
        send(8'h61, 0, 0); send(8'h62, 0, 0); send(8'h63, 1, 0);
        exp = '0; exp[511:480] = 32'h61626380; exp[63:0] = 64'h18;
        blk("abc2", exp, 1, 2);
        fin("abc2", H_ABC);
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
